// File: rtl/stream_fifo_pkg.sv
// Shared helpers and reset constants for the stream FIFO.
// Optional status flags are controlled by the STREAM_FIFO_STATUS_EN macro.
package stream_fifo_pkg;

    // Pointer width: address bits plus one wrap bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

`ifdef STREAM_FIFO_STATUS_EN
    localparam logic RST_ALMOST_FULL  = 1'b0;
    localparam logic RST_ALMOST_EMPTY = 1'b1;
`endif

endpackage

// File: rtl/stream_fifo_mem.sv
// Unreset storage array with one write port and an asynchronous read port.
module stream_fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Synchronous write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_sync_fifo.sv
// Single-clock first-word-fall-through valid/ready FIFO with synchronous flush.
// Define STREAM_FIFO_STATUS_EN to build the registered almost_full/almost_empty flags.
module stream_sync_fifo
    import stream_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [ptr_w(DEPTH)-1:0]   count,
    output logic                      almost_full,
    output logic                      almost_empty
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned AW = PW - 1;

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     count_nxt;
    logic              full;
    logic              empty;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] rdata;

    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty     = (wr_ptr == rd_ptr);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : rdata;

    // Flush wins over any handshake in the same cycle.
    assign wr_en = in_valid && in_ready && !flush;
    assign rd_en = out_valid && out_ready && !flush;

    stream_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    // Next occupancy, shared by the count register and the status flags.
    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   count_nxt = count + PW'(1);
                2'b01:   count_nxt = count - PW'(1);
                default: count_nxt = count;
            endcase
        end
    end

    // Pointer and occupancy registers; the wrap bit toggles naturally on overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            count <= count_nxt;
        end
    end

`ifdef STREAM_FIFO_STATUS_EN
    // Status flags registered from the next count so they track count with no lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            almost_full  <= RST_ALMOST_FULL;
            almost_empty <= RST_ALMOST_EMPTY;
        end else begin
            almost_full  <= (count_nxt >= PW'(AF_THRESH));
            almost_empty <= (count_nxt <= PW'(AE_THRESH));
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^{AF_THRESH, AE_THRESH};
    assign almost_full   = 1'b0;
    assign almost_empty  = 1'b0;
`endif

endmodule
